// File: rtl/tx_gearbox.sv
// 64b/66b transmit gearbox: packs 2-bit sync headers and 32-bit payload words
// into a continuous stream of DATA_WIDTH-bit transceiver words. One pause
// cycle every SLOTS+1 cycles absorbs the header overhead.
module tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_data_valid,
  input  logic [HDR_WIDTH-1:0]  i_tx_sync_hdr,
  input  logic                  i_tx_sync_hdr_valid,
  output logic                  o_tx_data_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_underflow,
  output logic                  o_hdr_err
);

  // Word slots per period; the header bits of SLOTS/2 blocks add up to one
  // full output word, which is drained on the pause cycle.
  localparam int SLOTS = 2 * DATA_WIDTH / HDR_WIDTH;
  localparam int SW    = $clog2(SLOTS + 1);
  localparam int BW    = 2 * DATA_WIDTH;
  localparam int CW    = $clog2(BW + 1);
  localparam logic [SW-1:0] PAUSE = SW'(SLOTS);

  logic [SW-1:0]         seq_q, seq_d;
  logic                  phase_q, phase_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  uf_q, uf_d;
  logic                  he_q, he_d;

  logic                  slot;
  logic [DATA_WIDTH-1:0] word;
  logic [HDR_WIDTH-1:0]  hdr;
  logic [BW-1:0]         app;
  logic [BW-1:0]         cat;
  logic [CW-1:0]         app_len;

  // A word slot is every non-pause cycle outside reset.
  assign slot            = (seq_q != PAUSE) && !i_reset;
  assign o_tx_data_ready = slot;
  assign o_tx_data       = data_q;
  assign o_tx_underflow  = uf_q;
  assign o_hdr_err       = he_q;

  // Append this cycle's bits above the residual, emit the low word, keep the rest.
  always_comb begin
    seq_d   = (seq_q == PAUSE) ? '0 : seq_q + SW'(1);
    word    = i_tx_data_valid ? i_tx_data : '0;
    hdr     = i_tx_data_valid ? i_tx_sync_hdr : '0;
    app     = '0;
    app_len = '0;
    if (slot) begin
      if (!phase_q) begin
        app     = {{(BW - DATA_WIDTH - HDR_WIDTH){1'b0}}, word, hdr};
        app_len = CW'(DATA_WIDTH + HDR_WIDTH);
      end else begin
        app     = {{(BW - DATA_WIDTH){1'b0}}, word};
        app_len = CW'(DATA_WIDTH);
      end
    end
    // Occupancy peaks at 2*DATA_WIDTH (residual 30 + 34 appended), so BW suffices.
    cat     = {{DATA_WIDTH{1'b0}}, res_q} | (app << cnt_q);
    data_d  = cat[DATA_WIDTH-1:0];
    res_d   = cat[BW-1:DATA_WIDTH];
    cnt_d   = cnt_q + app_len - CW'(DATA_WIDTH);
    phase_d = slot ? ~phase_q : phase_q;
    uf_d    = slot && !i_tx_data_valid;
    // Header-valid must be high exactly on phase-0 words.
    he_d    = slot && i_tx_data_valid && (i_tx_sync_hdr_valid == phase_q);
  end

  // State and output registers; reset discards any buffered bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seq_q   <= '0;
      phase_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      uf_q    <= 1'b0;
      he_q    <= 1'b0;
    end else begin
      seq_q   <= seq_d;
      phase_q <= phase_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      uf_q    <= uf_d;
      he_q    <= he_d;
    end
  end

endmodule

// File: tb/tb_tx_gearbox.sv
// Testbench for tx_gearbox: hand-computed vector table after reset, then a
// long stream checked against a bit-queue serializer model via a scoreboard.
module tb_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic [1:0]  tx_hdr;
  logic        tx_hdr_valid;
  logic        ready;
  logic [31:0] out_data;
  logic        underflow;
  logic        hdr_err;

  tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_tx_data           (tx_data),
    .i_tx_data_valid     (tx_valid),
    .i_tx_sync_hdr       (tx_hdr),
    .i_tx_sync_hdr_valid (tx_hdr_valid),
    .o_tx_data_ready     (ready),
    .o_tx_data           (out_data),
    .o_tx_underflow      (underflow),
    .o_hdr_err           (hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        uf;
    logic        he;
  } exp_t;

  typedef struct {
    logic [1:0]  hdr;
    logic        hv;
    logic [31:0] data;
    logic        v;
    logic [31:0] exp_data;
    logic        exp_uf;
    logic        exp_he;
  } vec_t;

  exp_t  exp_q[$];
  bit    mbits[$];
  int    mseq;
  bit    mphase;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    words;
  int    ready_lows;
  vec_t  tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, predict with the serializer model, compare after the edge.
  task automatic step(input logic r, input logic [1:0] h, input logic hv,
                      input logic [31:0] d, input logic v);
    exp_t        e;
    logic [31:0] wd;
    logic [1:0]  hd;
    rst = r; tx_hdr = h; tx_hdr_valid = hv; tx_data = d; tx_valid = v;
    #1;
    check("ready", {31'b0, ready}, {31'b0, (!r && mseq != 32)});
    if (!ready) ready_lows++;
    e.data = '0; e.uf = 1'b0; e.he = 1'b0;
    if (r) begin
      mseq = 0; mphase = 1'b0; mbits.delete();
    end else begin
      if (mseq != 32) begin
        wd = v ? d : 32'h0;
        hd = v ? h : 2'b00;
        if (!mphase) for (int i = 0; i < 2; i++) mbits.push_back(hd[i]);
        for (int i = 0; i < 32; i++) mbits.push_back(wd[i]);
        e.uf = !v;
        e.he = v && (hv != !mphase);
        mphase = !mphase;
        words++;
      end
      check("model_occupancy", {31'b0, mbits.size() >= 32}, 32'd1);
      for (int i = 0; i < 32; i++)
        if (mbits.size() > 0) e.data[i] = mbits.pop_front();
      mseq = (mseq == 32) ? 0 : mseq + 1;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("data", out_data, e.data);
    check("underflow", {31'b0, underflow}, {31'b0, e.uf});
    check("hdr_err", {31'b0, hdr_err}, {31'b0, e.he});
  endtask

  task automatic stream_step(input bit force_uf, input bit force_he);
    logic [31:0] d;
    d = $urandom;
    if (mseq == 32)
      step(1'b0, 2'b11, 1'b1, d, 1'b0);   // pause-cycle junk must be ignored
    else
      step(1'b0, mphase ? 2'b00 : 2'b01 + 2'(d[0]), force_he ? 1'b1 : !mphase,
           d, !force_uf);
  endtask

  initial begin
    bit uf_done, he_done;
    mseq = 0; mphase = 1'b0; words = 0; ready_lows = 0;

    // Expected words worked out by hand from the bit ordering.
    tbl[0] = '{2'b01, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0};
    tbl[1] = '{2'b00, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0003, 1'b0, 1'b0};
    tbl[2] = '{2'b10, 1'b1, 32'h1234_5678, 1'b1, 32'h2345_6788, 1'b0, 1'b0};
    tbl[3] = '{2'b00, 1'b0, 32'hA5A5_A5A5, 1'b1, 32'h5A5A_5A51, 1'b0, 1'b0};
    tbl[4] = '{2'b11, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_000A, 1'b1, 1'b0};
    tbl[5] = '{2'b00, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFC0, 1'b0, 1'b1};

    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b1, 32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 6; i++) begin
      step(1'b0, tbl[i].hdr, tbl[i].hv, tbl[i].data, tbl[i].v);
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
      check($sformatf("tbl%0d_uf", i), {31'b0, underflow}, {31'b0, tbl[i].exp_uf});
      check($sformatf("tbl%0d_he", i), {31'b0, hdr_err}, {31'b0, tbl[i].exp_he});
    end

    // Continuous stream of 40 further blocks with one underflow and one header error.
    words = 0; ready_lows = 0; uf_done = 0; he_done = 0;
    for (int c = 0; c < 200 && words < 80; c++) begin
      if (!uf_done && words >= 20 && mseq != 32 && !mphase) begin
        stream_step(1'b1, 1'b0); uf_done = 1;
      end else if (!he_done && words >= 41 && mseq != 32 && mphase) begin
        stream_step(1'b0, 1'b1); he_done = 1;
      end else stream_step(1'b0, 1'b0);
    end
    check("stream_words", words, 80);
    check("stream_pauses", ready_lows, 2);

    // Run to seq 17 (mid-block), reset, then restart from a fresh block.
    for (int c = 0; c < 40 && mseq != 17; c++) stream_step(1'b0, 1'b0);
    check("mid_block_phase", {31'b0, mphase}, 32'd1);
    step(1'b1, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 2'b10, 1'b1, 32'h8000_0001, 1'b1);
    check("restart_first_word", out_data, 32'h0000_0006);
    ready_lows = 0;
    for (int c = 0; c < 40; c++) stream_step(1'b0, 1'b0);
    check("restart_pause_count", ready_lows, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
